mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-requester arbiter for the single byte-wide main-memory port. Port 0 is the CPU (@, !, instruction and literal fetch traffic); port 1 is the image loader/debug host that fills or inspects memory while the CPU runs. It issues one memory command per cycle and routes read data back by tag. A per-port lock keeps two-byte (16-bit word) accesses atomic.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 8, memory data width
READ_LATENCY, 1, cycles from mem_en (read) to mem_rdata valid; legal 1..4
MAX_LOCK, 4, max consecutive locked grants to one port before forced release; legal 2..15

Ports:
clock  in  1  sole clock, rising edge
reset_n  in  1  asynchronous, active-low reset
req  in  2  per-port request; held until gnt
we  in  2  per-port write enable (0 = read)
lock  in  2  per-port: keep grant for the next cycle
addr0  in  ADDR_W  port 0 address
addr1  in  ADDR_W  port 1 address
wdata0  in  DATA_W  port 0 write data
wdata1  in  DATA_W  port 1 write data
gnt  out  2  one-hot or zero; command accepted this cycle
rvalid  out  2  per-port read data valid
rdata  out  DATA_W  read data, shared by both ports, qualified by rvalid
mem_en  out  1  memory command strobe
mem_we  out  1  memory write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, READ_LATENCY after the command

Behaviour:
- Grant is combinational in the request cycle. At most one gnt bit is set. mem_en = |gnt. mem_we, mem_addr and mem_wdata are muxed from the granted port. When mem_en=0, mem_we=0 and mem_addr/mem_wdata hold don't-care.
- Registered state:
  - last (port last granted). Reset value 1, so port 0 wins the first contest.
  - owner_valid, owner (lock holder). Reset values 0, 0.
  - lock_cnt[3:0]. Reset value 0.
  - Read tag pipeline, READ_LATENCY stages of {valid, port}. Reset value all invalid.
- Arbitration priority, evaluated each cycle:
  1. If owner_valid and req[owner] and lock_cnt < MAX_LOCK, grant owner.
  2. Otherwise, if exactly one req is set, grant it.
  3. Otherwise, if both are set, grant !last (round-robin).
  4. Otherwise, no grant.
- Lock update on a grant to port p:
  - If lock[p]=1 and lock_cnt+1 < MAX_LOCK: owner<=p, owner_valid<=1, lock_cnt<=lock_cnt+1.
  - Otherwise: owner_valid<=0, lock_cnt<=0.
  - last<=p on every grant.
- Lock release without a grant: if there is no grant, or the owner dropped req, then owner_valid<=0 and lock_cnt<=0.
- A forced release at MAX_LOCK hands the next contested cycle to the other port; a new lock by the same port starts after that.
- Read return:
  - A granted read pushes {1, p} into tag stage 0; a write or idle cycle pushes invalid.
  - The tag pipeline advances every cycle.
  - rvalid[p] = last stage valid && port==p. rdata = mem_rdata, passed through combinationally.
  - Exactly one rvalid per granted read, in issue order, READ_LATENCY cycles after gnt.
- Writes produce no response; gnt is the completion.
- Both reqs with the same address: serialized, no hazard logic. The memory orders them.
- Reset asserted: gnt, mem_en, mem_we and rvalid go to 0 immediately (all combinational outputs are gated by reset_n). All state returns to reset values. In-flight reads are discarded, and no rvalid is produced for them after release.
- Reset release: first grant possible in the first cycle with reset_n=1.
- lock on a non-granted port has no effect.
- A req dropped without gnt is legal (abandon) and has no side effects.

Decomposition:
- Package mem_arbiter_pkg: port index constants PORT_CPU=0 and PORT_HOST=1, the tag struct {valid, port}, and READ_LATENCY/MAX_LOCK legality checks.
- Sub-module rd_tag_pipe: parameterized READ_LATENCY-stage shift register of tags with async clear. Everything else stays in mem_arbiter.

Test Plan:
- Reset, then both ports read continuously (addr0=0x0010, addr1=0x0200, lock=0): gnt alternates 01,10,01,... starting with port 0. rvalid[0] one cycle after each port-0 grant with memory[0x0010], and likewise rvalid[1] with memory[0x0200].
- Port 0 writes 0x34 to 0x0100 with lock=1, then 0x12 to 0x0101 with lock=0, while port 1 requests a read of 0x0100: port 0 gets two consecutive grants, port 1 is granted on the third cycle and gets rvalid with 0x34.
- MAX_LOCK=4, port 0 holds req and lock while port 1 requests: port 0 gets exactly 4 consecutive grants, port 1 then gets 1, and the pattern repeats.
- READ_LATENCY=3, alternating reads on both ports: rvalid and data appear exactly 3 cycles after each gnt on the correct port, with no drops or duplicates.
- Assert reset_n=0 one cycle after a granted read (READ_LATENCY=2): rvalid never asserts. After release, port 1 alone requesting is granted in the first cycle.
- Port 1 alone requests reads for 8 cycles: gnt[1]=1 every cycle, mem_en=1 every cycle, and 8 rvalid[1] pulses follow.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the two-port main-memory arbiter:
//   port index constants, the read-return tag carried through the
//   latency pipeline, and range checks for the build-time parameters.
package mem_arbiter_pkg;

  localparam int PORT_CPU  = 0;
  localparam int PORT_HOST = 1;

  // One entry of the read-return pipeline: which port a read belongs to.
  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

  function automatic bit read_latency_ok(input int lat);
    return (lat >= 1) && (lat <= 4);
  endfunction

  function automatic bit max_lock_ok(input int max_lock);
    return (max_lock >= 2) && (max_lock <= 15);
  endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe
//   DEPTH-stage shift register of read tags. Stage 0 captures the tag of
//   the command issued this cycle; the last stage lines up with the
//   memory's read data. Asynchronous clear drops all in-flight tags.
// Ports:
//   clock, reset_n   clock / async active-low clear
//   i_valid, i_port  tag of the command issued this cycle
//   o_valid, o_port  tag whose read data is on the memory bus now
module rd_tag_pipe
  import mem_arbiter_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_valid,
  input  logic i_port,
  output logic o_valid,
  output logic o_port
);

  rd_tag_t r_stage [DEPTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= rd_tag_t'{valid: i_valid, port: i_port};
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_valid = r_stage[DEPTH-1].valid;
  assign o_port  = r_stage[DEPTH-1].port;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates the byte-wide main-memory port between the CPU (port 0)
//   and the loader/debug host (port 1). Grant is combinational in the
//   request cycle; round-robin on contention, with a per-port lock that
//   keeps two-byte accesses together, capped at MAX_LOCK grants.
//   Read data is returned on the shared rdata bus, steered by a tag pipe.
// Ports:
//   clock, reset_n            clock / async active-low reset
//   req, we, lock             per-port request, write enable, lock
//   addr0/1, wdata0/1         per-port command fields
//   gnt                       one-hot (or zero) command acceptance
//   rvalid, rdata             per-port read return, shared data
//   mem_en/we/addr/wdata      memory command
//   mem_rdata                 memory read data, READ_LATENCY later
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int MAX_LOCK     = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [1:0]        lock,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [1:0]        rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
    $fatal(1, "mem_arbiter: READ_LATENCY must be 1..4");
  end
  if (!max_lock_ok(MAX_LOCK)) begin : g_bad_max_lock
    $fatal(1, "mem_arbiter: MAX_LOCK must be 2..15");
  end

  logic       r_last;
  logic       r_owner_valid;
  logic       r_owner;
  logic [3:0] r_lock_cnt;

  logic [1:0] w_gnt;
  logic       w_port;
  logic       w_owner_hit;
  logic [3:0] w_cnt_base;
  logic [4:0] w_cnt_inc;
  logic       w_lock_take;
  logic       w_tag_valid;
  logic       w_tag_port;

  always_comb begin
    w_gnt       = 2'b00;
    w_owner_hit = r_owner_valid && req[r_owner] && (r_lock_cnt < 4'(MAX_LOCK));
    if (!reset_n) begin
      w_gnt = 2'b00;
    end else if (w_owner_hit) begin
      w_gnt = r_owner ? 2'b10 : 2'b01;
    end else begin
      case (req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign w_port = w_gnt[1];

  // The count only carries over while the same port keeps the lock; a
  // grant to the other port means the previous owner gave up its request.
  assign w_cnt_base  = (r_owner_valid && (r_owner == w_port)) ? r_lock_cnt : 4'd0;
  assign w_cnt_inc   = {1'b0, w_cnt_base} + 5'd1;
  assign w_lock_take = lock[w_port] && (w_cnt_inc < 5'(MAX_LOCK));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last        <= 1'b1;
      r_owner_valid <= 1'b0;
      r_owner       <= 1'b0;
      r_lock_cnt    <= 4'd0;
    end else if (|w_gnt) begin
      r_last <= w_port;
      if (w_lock_take) begin
        r_owner       <= w_port;
        r_owner_valid <= 1'b1;
        r_lock_cnt    <= w_cnt_inc[3:0];
      end else begin
        r_owner_valid <= 1'b0;
        r_lock_cnt    <= 4'd0;
      end
    end else begin
      r_owner_valid <= 1'b0;
      r_lock_cnt    <= 4'd0;
    end
  end

  assign gnt       = w_gnt;
  assign mem_en    = |w_gnt;
  assign mem_we    = mem_en && we[w_port];
  assign mem_addr  = w_port ? addr1 : addr0;
  assign mem_wdata = w_port ? wdata1 : wdata0;

  rd_tag_pipe #(
    .DEPTH(READ_LATENCY)
  ) u_rd_tag_pipe (
    .clock  (clock),
    .reset_n(reset_n),
    .i_valid(mem_en && !mem_we),
    .i_port (w_port),
    .o_valid(w_tag_valid),
    .o_port (w_tag_port)
  );

  assign rvalid[PORT_CPU]  = reset_n && w_tag_valid && !w_tag_port;
  assign rvalid[PORT_HOST] = reset_n && w_tag_valid && w_tag_port;
  assign rdata             = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Three arbiter instances (READ_LATENCY 1, 2, 3; MAX_LOCK 4) share the
//   request inputs; each has its own memory model. Each scenario task
//   watches one instance. Expected read returns are queued when a read
//   is granted and popped when rvalid appears.
module tb_mem_arbiter;

  localparam int NI = 3;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req     = 2'b00;
  logic [1:0]  we      = 2'b00;
  logic [1:0]  lock    = 2'b00;
  logic [15:0] addr0   = 16'h0;
  logic [15:0] addr1   = 16'h0;
  logic [7:0]  wdata0  = 8'h0;
  logic [7:0]  wdata1  = 8'h0;

  logic [1:0]  gnt_a       [NI];
  logic [1:0]  rvalid_a    [NI];
  logic [7:0]  rdata_a     [NI];
  logic        mem_en_a    [NI];
  logic        mem_we_a    [NI];
  logic [15:0] mem_addr_a  [NI];
  logic [7:0]  mem_wdata_a [NI];
  logic [7:0]  mem_rdata_a [NI];

  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [7:0] mem_q   [0:65535];
    bit         wr_q    [0:65535];
    logic [7:0] rd_pipe [0:g];

    mem_arbiter #(
      .ADDR_W      (16),
      .DATA_W      (8),
      .READ_LATENCY(g + 1),
      .MAX_LOCK    (4)
    ) u_dut (
      .clock    (clock),
      .reset_n  (reset_n),
      .req      (req),
      .we       (we),
      .lock     (lock),
      .addr0    (addr0),
      .addr1    (addr1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .gnt      (gnt_a[g]),
      .rvalid   (rvalid_a[g]),
      .rdata    (rdata_a[g]),
      .mem_en   (mem_en_a[g]),
      .mem_we   (mem_we_a[g]),
      .mem_addr (mem_addr_a[g]),
      .mem_wdata(mem_wdata_a[g]),
      .mem_rdata(mem_rdata_a[g])
    );

    always @(posedge clock) begin
      rd_pipe[0] <= wr_q[mem_addr_a[g]] ? mem_q[mem_addr_a[g]] : pat(mem_addr_a[g]);
      for (int i = 1; i <= g; i++) rd_pipe[i] <= rd_pipe[i-1];
      if (mem_en_a[g] && mem_we_a[g]) begin
        mem_q[mem_addr_a[g]] <= mem_wdata_a[g];
        wr_q[mem_addr_a[g]]  <= 1'b1;
      end
    end

    assign mem_rdata_a[g] = rd_pipe[g];
  end

  typedef struct {
    int         due;
    logic       port;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   host_pulses = 0;

  logic [1:0]  s_gnt;
  logic [1:0]  s_rvalid;
  logic [7:0]  s_rdata;
  logic        s_mem_en;
  logic        s_mem_we;
  logic [15:0] s_mem_addr;
  logic [7:0]  s_mem_wdata;
  int          s_cyc;

  task automatic sample(input int k);
    s_gnt       = gnt_a[k];
    s_rvalid    = rvalid_a[k];
    s_rdata     = rdata_a[k];
    s_mem_en    = mem_en_a[k];
    s_mem_we    = mem_we_a[k];
    s_mem_addr  = mem_addr_a[k];
    s_mem_wdata = mem_wdata_a[k];
    s_cyc       = cyc;
  endtask

  task automatic drive(input int k, input logic [1:0] r, input logic [1:0] w,
                       input logic [1:0] l, input logic [15:0] a0, input logic [15:0] a1,
                       input logic [7:0] d0, input logic [7:0] d1);
    @(negedge clock);
    req = r; we = w; lock = l;
    addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
    #1 sample(k);
  endtask

  task automatic sb_push(input int lat, input logic p, input logic [7:0] d);
    sb_q.push_back('{due: s_cyc + lat, port: p, data: d});
  endtask

  // Pops one expected return for every rvalid pulse seen on the sample.
  task automatic sb_pop_compare(input string name);
    exp_t e;
    if (s_rvalid !== 2'b00) begin
      n_cmp++;
      if (s_rvalid[1] === 1'b1) host_pulses++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s: unexpected rvalid=%b rdata=%h at cycle %0d, expected none",
                 name, s_rvalid, s_rdata, s_cyc);
      end else begin
        e = sb_q.pop_front();
        if (s_rvalid !== (e.port ? 2'b10 : 2'b01) || s_rdata !== e.data || s_cyc != e.due) begin
          n_bad++;
          $display("FAIL %s: got rvalid=%b rdata=%h cycle %0d, expected port%0d rdata=%h cycle %0d",
                   name, s_rvalid, s_rdata, s_cyc, e.port, e.data, e.due);
        end
      end
    end
  endtask

  task automatic drain(input int k, input string name);
    for (int i = 0; i < 6; i++) begin
      drive(k, 2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
      sb_pop_compare(name);
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_missing: %0d reads never returned, expected 0", name, sb_q.size());
    end
    sb_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; req = 2'b00; we = 2'b00; lock = 2'b00;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    sb_q.delete();
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset_n = 1'b0; req = 2'b11; we = 2'b11; addr0 = 16'h0010; addr1 = 16'h0200;
    #1 sample(0);
    n_cmp++;
    if (s_gnt !== 2'b00 || s_mem_en !== 1'b0 || s_mem_we !== 1'b0 || s_rvalid !== 2'b00) begin
      n_bad++;
      $display("FAIL reset_outputs: gnt=%b mem_en=%b mem_we=%b rvalid=%b, expected all 0",
               s_gnt, s_mem_en, s_mem_we, s_rvalid);
    end
    @(negedge clock);
    reset_n = 1'b1; we = 2'b00;
    #1 sample(0);
    n_cmp++;
    if (s_gnt !== 2'b01 || s_mem_en !== 1'b1 || s_mem_addr !== 16'h0010) begin
      n_bad++;
      $display("FAIL reset_first_grant: gnt=%b mem_en=%b addr=%h, expected 01 1 0010",
               s_gnt, s_mem_en, s_mem_addr);
    end
  endtask

  task automatic test_round_robin();
    logic p;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(0, 2'b11, 2'b00, 2'b00, 16'h0010, 16'h0200, 8'h0, 8'h0);
      sb_pop_compare("rr_return");
      p = i[0];
      n_cmp++;
      if (s_gnt !== (p ? 2'b10 : 2'b01) || s_mem_en !== 1'b1 || s_mem_we !== 1'b0 ||
          s_mem_addr !== (p ? 16'h0200 : 16'h0010)) begin
        n_bad++;
        $display("FAIL rr_grant[%0d]: gnt=%b en=%b we=%b addr=%h, expected port%0d read",
                 i, s_gnt, s_mem_en, s_mem_we, s_mem_addr, p);
      end
      sb_push(1, p, pat(p ? 16'h0200 : 16'h0010));
    end
    drain(0, "rr_return");
  endtask

  task automatic test_locked_word();
    do_reset();
    drive(0, 2'b11, 2'b01, 2'b01, 16'h0100, 16'h0100, 8'h34, 8'h00);
    n_cmp++;
    if (s_gnt !== 2'b01 || s_mem_we !== 1'b1 || s_mem_addr !== 16'h0100 || s_mem_wdata !== 8'h34) begin
      n_bad++;
      $display("FAIL lock_wr_lo: gnt=%b we=%b addr=%h wdata=%h, expected 01 1 0100 34",
               s_gnt, s_mem_we, s_mem_addr, s_mem_wdata);
    end
    drive(0, 2'b11, 2'b01, 2'b00, 16'h0101, 16'h0100, 8'h12, 8'h00);
    n_cmp++;
    if (s_gnt !== 2'b01 || s_mem_we !== 1'b1 || s_mem_addr !== 16'h0101 || s_mem_wdata !== 8'h12) begin
      n_bad++;
      $display("FAIL lock_wr_hi: gnt=%b we=%b addr=%h wdata=%h, expected 01 1 0101 12",
               s_gnt, s_mem_we, s_mem_addr, s_mem_wdata);
    end
    drive(0, 2'b10, 2'b00, 2'b00, 16'h0000, 16'h0100, 8'h00, 8'h00);
    n_cmp++;
    if (s_gnt !== 2'b10 || s_mem_we !== 1'b0 || s_mem_addr !== 16'h0100) begin
      n_bad++;
      $display("FAIL lock_host_rd: gnt=%b we=%b addr=%h, expected 10 0 0100",
               s_gnt, s_mem_we, s_mem_addr);
    end
    sb_push(1, 1'b1, 8'h34);
    drain(0, "lock_host_return");
  endtask

  task automatic test_lock_limit();
    logic p;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(0, 2'b11, 2'b00, 2'b01, 16'h0020, 16'h0030, 8'h0, 8'h0);
      sb_pop_compare("maxlock_return");
      p = ((i % 5) == 4);
      n_cmp++;
      if (s_gnt !== (p ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL maxlock_grant[%0d]: gnt=%b, expected %b", i, s_gnt, p ? 2'b10 : 2'b01);
      end
      sb_push(1, p, pat(p ? 16'h0030 : 16'h0020));
    end
    drain(0, "maxlock_return");
  endtask

  task automatic test_latency3();
    logic        p;
    logic [15:0] a0;
    logic [15:0] a1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a0 = 16'h0400 + 16'(i);
      a1 = 16'h0500 + 16'(i);
      drive(2, 2'b11, 2'b00, 2'b00, a0, a1, 8'h0, 8'h0);
      sb_pop_compare("lat3_return");
      p = i[0];
      n_cmp++;
      if (s_gnt !== (p ? 2'b10 : 2'b01)) begin
        n_bad++;
        $display("FAIL lat3_grant[%0d]: gnt=%b, expected %b", i, s_gnt, p ? 2'b10 : 2'b01);
      end
      sb_push(3, p, pat(p ? a1 : a0));
    end
    drain(2, "lat3_return");
  endtask

  task automatic test_reset_inflight();
    do_reset();
    drive(1, 2'b01, 2'b00, 2'b00, 16'h0040, 16'h0000, 8'h0, 8'h0);
    n_cmp++;
    if (s_gnt !== 2'b01) begin
      n_bad++;
      $display("FAIL inflight_grant: gnt=%b, expected 01", s_gnt);
    end
    @(negedge clock);
    reset_n = 1'b0; req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #1 sample(1);
      n_cmp++;
      if (s_rvalid !== 2'b00 || s_gnt !== 2'b00 || s_mem_en !== 1'b0) begin
        n_bad++;
        $display("FAIL inflight_in_reset[%0d]: rvalid=%b gnt=%b mem_en=%b, expected 00 00 0",
                 i, s_rvalid, s_gnt, s_mem_en);
      end
      @(negedge clock);
    end
    reset_n = 1'b1; req = 2'b10; addr1 = 16'h0050;
    #1 sample(1);
    n_cmp++;
    if (s_gnt !== 2'b10 || s_rvalid !== 2'b00) begin
      n_bad++;
      $display("FAIL release_first_grant: gnt=%b rvalid=%b, expected 10 00", s_gnt, s_rvalid);
    end
    sb_push(2, 1'b1, pat(16'h0050));
    drain(1, "inflight_return");
  endtask

  task automatic test_host_stream();
    logic [15:0] a1;
    do_reset();
    host_pulses = 0;
    for (int i = 0; i < 8; i++) begin
      a1 = 16'h0300 + 16'(i);
      drive(0, 2'b10, 2'b00, 2'b00, 16'h0000, a1, 8'h0, 8'h0);
      sb_pop_compare("host_return");
      n_cmp++;
      if (s_gnt !== 2'b10 || s_mem_en !== 1'b1 || s_mem_addr !== a1) begin
        n_bad++;
        $display("FAIL host_grant[%0d]: gnt=%b en=%b addr=%h, expected 10 1 %h",
                 i, s_gnt, s_mem_en, s_mem_addr, a1);
      end
      sb_push(1, 1'b1, pat(a1));
    end
    drain(0, "host_return");
    n_cmp++;
    if (host_pulses != 8) begin
      n_bad++;
      $display("FAIL host_pulse_count: got %0d rvalid[1] pulses, expected 8", host_pulses);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_locked_word();
    test_lock_limit();
    test_latency3();
    test_reset_inflight();
    test_host_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the scenarios completed");
    $fatal(1, "watchdog");
  end

endmodule
